jk_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bank of NBITS JK flip-flops between NREQ requesters. Each requester submits a per-bit JK command vector over a valid/ready handshake. The arbiter drives the bank's j/k inputs for exactly one cycle per granted command, then reads back q to check it against the expected JK result. It sits between software-visible control agents and the flip-flop bank, and reports mismatches through a sticky error flag and a counter.

---
 rtl/jk_bank_arbiter.sv | 158 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin sequencer that shares one bank of JK flip-flops between NREQ
// requesters, applying one command per grant and checking the readback.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*NBITS-1:0] req_j,
    input  logic [NREQ*NBITS-1:0] req_k,
    output logic [NBITS-1:0]      j_out,
    output logic [NBITS-1:0]      k_out,
    input  logic [NBITS-1:0]      q_in,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  err,
    output logic [7:0]            err_cnt,
    input  logic                  err_clr
);
    localparam int PW = IDW + 1;
    localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_q;
    logic [NBITS-1:0] j_q;
    logic [NBITS-1:0] k_q;
    logic [NBITS-1:0] exp_q;
    logic [NREQ-1:0]  ready_q;
    logic             busy_q;
    logic             err_q;
    logic [7:0]       cnt_q;

    logic             found_s;
    logic             hit_s;
    logic [IDW-1:0]   pick_s;
    logic [PW-1:0]    wrap_s;
    logic [PW-1:0]    idx_s;
    logic [NBITS-1:0] sel_j_s;
    logic [NBITS-1:0] sel_k_s;
    logic             mismatch_s;
    logic [7:0]       cnt_base_s;
    logic [7:0]       cnt_d;
    logic             err_d;
    logic [IDW-1:0]   ptr_d;

    // Next value of a JK bank given its inputs and current state.
    function automatic logic [NBITS-1:0] jk_eval(input logic [NBITS-1:0] j,
                                                 input logic [NBITS-1:0] k,
                                                 input logic [NBITS-1:0] q);
        return (j & ~q) | (~k & q);
    endfunction

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        pick_s  = '0;
        wrap_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            wrap_s  = {1'b0, ptr_q} + PW'(i);
            idx_s   = (wrap_s >= PW'(NREQ)) ? (wrap_s - PW'(NREQ)) : wrap_s;
            hit_s   = !found_s && (|(req_valid & (REQ_ONE << idx_s[IDW-1:0])));
            pick_s  = hit_s ? idx_s[IDW-1:0] : pick_s;
            found_s = found_s | hit_s;
        end
    end

    assign sel_j_s = NBITS'(req_j >> (int'(pick_s) * NBITS));
    assign sel_k_s = NBITS'(req_k >> (int'(pick_s) * NBITS));
    assign ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : (grant_q + IDW'(1));

    // Error bookkeeping: a mismatch in CHECK takes priority over err_clr.
    always_comb begin
        mismatch_s = (state_q == S_CHECK) && (q_in != exp_q);
        cnt_base_s = err_clr ? 8'd0 : cnt_q;
        if (mismatch_s) begin
            err_d = 1'b1;
            cnt_d = (cnt_base_s == 8'hFF) ? 8'hFF : (cnt_base_s + 8'd1);
        end else begin
            err_d = err_clr ? 1'b0 : err_q;
            cnt_d = cnt_base_s;
        end
    end

    // Sequencer FSM; every output is driven from a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            exp_q   <= '0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    ready_q <= '0;
                    if (found_s) begin
                        grant_q <= pick_s;
                        j_q     <= sel_j_s;
                        k_q     <= sel_k_s;
                        busy_q  <= 1'b1;
                        state_q <= S_APPLY;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_APPLY: begin
                    // q_in still shows the pre-command value on this edge.
                    exp_q   <= jk_eval(j_q, k_q, q_in);
                    j_q     <= '0;
                    k_q     <= '0;
                    ready_q <= REQ_ONE << grant_q;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    ready_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= S_IDLE;
                end
                default: begin
                    j_q     <= '0;
                    k_q     <= '0;
                    ready_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: a behavioural JK bank plus a
// transaction-level model of grant order, bank contents and error counting.
module tb_jk_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [3:0]  req_ready;
    logic [31:0] req_j = 32'h0;
    logic [31:0] req_k = 32'h0;
    logic [7:0]  j_out, k_out, q_in;
    logic        busy;
    logic [2:0]  grant_id;
    logic        err;
    logic [7:0]  err_cnt;
    logic        err_clr = 1'b0;

    logic [7:0]  bank_q = 8'h00;
    logic        stuck_en = 1'b0;
    int          cyc_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    int          mdl_ptr = 0;
    logic [7:0]  mdl_q = 8'h00;
    logic        mdl_err = 1'b0;
    int          mdl_cnt = 0;
    logic [7:0]  cur_j [4];
    logic [7:0]  cur_k [4];

    int          o_gid, o_napply, o_cyc;
    logic [7:0]  o_jo, o_ko, o_jkz, o_qc;
    logic [3:0]  o_rdy;
    bit          o_ok;

    jk_bank_arbiter #(.NREQ(4), .NBITS(8), .IDW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_j(req_j), .req_k(req_k), .j_out(j_out), .k_out(k_out), .q_in(q_in),
        .busy(busy), .grant_id(grant_id), .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] jk_model(input logic [7:0] j, input logic [7:0] k, input logic [7:0] q);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int o = 0; o < 4; o++) begin
            if (v[(ptr + o) % 4]) return (ptr + o) % 4;
        end
        return -1;
    endfunction

    // The physical bank: updates from j_out/k_out on every rising edge.
    always @(posedge clk) bank_q <= jk_model(j_out, k_out, bank_q);
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    assign q_in = stuck_en ? 8'h00 : bank_q;

    task automatic set_req(input int r, input logic [7:0] j, input logic [7:0] k);
        req_j[r*8 +: 8] = j;
        req_k[r*8 +: 8] = k;
        cur_j[r] = j;
        cur_k[r] = k;
        req_valid[r] = 1'b1;
    endtask

    // Observe one command from grant to ready pulse (bounded); no checking here.
    task automatic wait_done();
        o_gid = -1; o_napply = 0; o_jo = 8'h00; o_ko = 8'h00; o_jkz = 8'h00;
        o_qc = 8'h00; o_rdy = 4'h0; o_cyc = 0; o_ok = 1'b0;
        for (int c = 0; c < 16 && !o_ok; c++) begin
            @(negedge clk);
            if (req_ready != 4'h0) begin
                o_rdy = req_ready; o_qc = q_in; o_jkz = j_out | k_out; o_cyc = cyc_cnt; o_ok = 1'b1;
            end else if (busy) begin
                o_gid = int'(grant_id); o_napply++; o_jo = j_out; o_ko = k_out;
            end
        end
    endtask

    task automatic txn(input int r, input logic [7:0] j, input logic [7:0] k);
        set_req(r, j, k);
        wait_done();
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (j_out !== 8'h00 || k_out !== 8'h00) begin errors++; $display("FAIL reset_jk got %h/%h want 00/00", j_out, k_out); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL reset_busy_id got %b/%0d want 0/0", busy, grant_id); end
        checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", err, err_cnt); end
        rst_n = 1'b1;
        mdl_ptr = 0; mdl_err = 1'b0; mdl_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] e;
        e = jk_model(8'hF0, 8'h0F, mdl_q);
        txn(2, 8'hF0, 8'h0F);
        checks++; if (!o_ok || o_gid != rr_pick(mdl_ptr, 4'b0100)) begin errors++; $display("FAIL single_grant got %0d ok %0d want 2", o_gid, o_ok); end
        checks++; if (o_napply != 1 || o_jo !== 8'hF0 || o_ko !== 8'h0F) begin errors++; $display("FAIL single_apply got n=%0d %h/%h want 1 F0/0F", o_napply, o_jo, o_ko); end
        checks++; if (o_jkz !== 8'h00 || o_rdy !== 4'b0100) begin errors++; $display("FAIL single_check got jk %h rdy %b want 00 0100", o_jkz, o_rdy); end
        checks++; if (o_qc !== e || o_qc !== 8'hF0) begin errors++; $display("FAIL single_q got %h want F0", o_qc); end
        checks++; if (err !== 1'b0 || req_ready !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_after got err %b rdy %b busy %b want 0", err, req_ready, busy); end
        mdl_q = e; mdl_ptr = 3;
    endtask

    task automatic test_toggle();
        txn(mdl_ptr, 8'hA5, 8'h5A);
        mdl_q = jk_model(8'hA5, 8'h5A, mdl_q); mdl_ptr = (mdl_ptr + 1) % 4;
        checks++; if (o_qc !== 8'hA5) begin errors++; $display("FAIL toggle_load got %h want A5", o_qc); end
        txn(mdl_ptr, 8'hFF, 8'hFF);
        mdl_q = jk_model(8'hFF, 8'hFF, mdl_q); mdl_ptr = (mdl_ptr + 1) % 4;
        checks++; if (o_qc !== 8'h5A) begin errors++; $display("FAIL toggle_q got %h want 5A", o_qc); end
        txn(mdl_ptr, 8'h00, 8'h00);
        mdl_ptr = (mdl_ptr + 1) % 4;
        checks++; if (o_qc !== 8'h5A || err !== 1'b0) begin errors++; $display("FAIL hold_q got %h err %b want 5A 0", o_qc, err); end
    endtask

    task automatic test_random();
        int r; logic [7:0] j, k, e;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(3, 0); j = 8'($urandom); k = 8'($urandom);
            e = jk_model(j, k, mdl_q);
            txn(r, j, k);
            checks++; if (!o_ok || o_gid != r || o_rdy !== (4'b0001 << r)) begin errors++; $display("FAIL rand_grant got id %0d rdy %b want %0d", o_gid, o_rdy, r); end
            checks++; if (o_jo !== j || o_ko !== k || o_napply != 1) begin errors++; $display("FAIL rand_apply got %h/%h n=%0d want %h/%h 1", o_jo, o_ko, o_napply, j, k); end
            checks++; if (o_qc !== e || err !== mdl_err) begin errors++; $display("FAIL rand_q got %h err %b want %h %b", o_qc, err, e, mdl_err); end
            mdl_q = e; mdl_ptr = (r + 1) % 4;
        end
    endtask

    task automatic test_round_robin();
        int exp_id, last_cyc; logic [7:0] e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_ptr = 0; mdl_err = 1'b0; mdl_cnt = 0;
        for (int i = 0; i < 4; i++) set_req(i, 8'($urandom), 8'($urandom));
        last_cyc = 0;
        for (int n = 0; n < 8; n++) begin
            exp_id = rr_pick(mdl_ptr, req_valid);
            e = jk_model(cur_j[exp_id], cur_k[exp_id], mdl_q);
            wait_done();
            checks++; if (!o_ok || o_rdy !== (4'b0001 << exp_id) || o_gid != exp_id) begin errors++; $display("FAIL rr_order got id %0d rdy %b want %0d", o_gid, o_rdy, exp_id); end
            checks++; if (o_qc !== e) begin errors++; $display("FAIL rr_q got %h want %h", o_qc, e); end
            if (n > 0) begin
                checks++; if (o_cyc - last_cyc != 3) begin errors++; $display("FAIL rr_gap got %0d want 3", o_cyc - last_cyc); end
            end
            last_cyc = o_cyc; mdl_q = e; mdl_ptr = (exp_id + 1) % 4;
            @(negedge clk);
            set_req(exp_id, 8'($urandom), 8'($urandom));
        end
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic serve_pending(input string tag);
        int exp_id; logic [7:0] e;
        for (int n = 0; n < 2; n++) begin
            exp_id = rr_pick(mdl_ptr, req_valid);
            e = jk_model(cur_j[exp_id], cur_k[exp_id], mdl_q);
            wait_done();
            checks++; if (!o_ok || o_gid != exp_id || o_rdy !== (4'b0001 << exp_id)) begin errors++; $display("FAIL %s_order got id %0d rdy %b want %0d", tag, o_gid, o_rdy, exp_id); end
            checks++; if (o_qc !== e) begin errors++; $display("FAIL %s_q got %h want %h", tag, o_qc, e); end
            mdl_q = e; mdl_ptr = (exp_id + 1) % 4;
            @(negedge clk);
            req_valid[exp_id] = 1'b0;
        end
    endtask

    task automatic test_wrap();
        txn(3, 8'($urandom), 8'($urandom));
        checks++; if (o_gid != 3) begin errors++; $display("FAIL wrap_pre got %0d want 3", o_gid); end
        mdl_q = jk_model(cur_j[3], cur_k[3], mdl_q); mdl_ptr = 0;
        set_req(1, 8'($urandom), 8'($urandom));
        set_req(3, 8'($urandom), 8'($urandom));
        serve_pending("wrap");
    endtask

    task automatic test_mismatch();
        int r; logic [7:0] e_vis;
        stuck_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = i % 4;
            e_vis = jk_model(8'h01, 8'h00, 8'h00);
            txn(r, 8'h01, 8'h00);
            if (e_vis != 8'h00) begin mdl_err = 1'b1; mdl_cnt = (mdl_cnt < 255) ? mdl_cnt + 1 : 255; end
            mdl_q = jk_model(8'h01, 8'h00, mdl_q); mdl_ptr = (r + 1) % 4;
            if (i == 0 || i == 253 || i == 299) begin
                checks++; if (err !== mdl_err || err_cnt !== 8'(mdl_cnt)) begin errors++; $display("FAIL mis_cnt_%0d got %b/%0d want %b/%0d", i, err, err_cnt, mdl_err, mdl_cnt); end
            end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; mdl_err = 1'b0; mdl_cnt = 0;
        checks++; if (err !== mdl_err || err_cnt !== 8'(mdl_cnt)) begin errors++; $display("FAIL mis_clear got %b/%0d want 0/0", err, err_cnt); end
        set_req(2, 8'h01, 8'h00);
        wait_done();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; req_valid[2] = 1'b0;
        mdl_err = 1'b1; mdl_cnt = 1; mdl_ptr = 3;
        checks++; if (!o_ok || err !== mdl_err || err_cnt !== 8'(mdl_cnt)) begin errors++; $display("FAIL mis_clr_race got %b/%0d want 1/1", err, err_cnt); end
        stuck_en = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; mdl_err = 1'b0; mdl_cnt = 0;
    endtask

    task automatic test_async_reset();
        txn(1, 8'($urandom), 8'($urandom));
        mdl_q = jk_model(cur_j[1], cur_k[1], mdl_q); mdl_ptr = 2;
        set_req(0, 8'($urandom), 8'($urandom));
        set_req(3, 8'($urandom) | 8'h01, 8'($urandom));
        @(negedge clk);
        checks++; if (busy !== 1'b1 || int'(grant_id) != rr_pick(mdl_ptr, 4'b1001) || j_out !== cur_j[3]) begin errors++; $display("FAIL ar_apply got busy %b id %0d j %h want 1 3 %h", busy, grant_id, j_out, cur_j[3]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (j_out !== 8'h00 || k_out !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL ar_immediate got %h/%h busy %b want 00/00 0", j_out, k_out, busy); end
        @(negedge clk);
        checks++; if (req_ready !== 4'h0 || busy !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL ar_held got rdy %b busy %b id %0d want 0", req_ready, busy, grant_id); end
        rst_n = 1'b1;
        mdl_ptr = 0; mdl_err = 1'b0; mdl_cnt = 0;
        serve_pending("ar");
        checks++; if (err !== mdl_err || err_cnt !== 8'(mdl_cnt)) begin errors++; $display("FAIL ar_err got %b/%0d want 0/0", err, err_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_random();
        test_round_robin();
        test_wrap();
        test_mismatch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
